i2c_target_responder: RTL and testbench

//  Synchronous I2C target: answers the I2C controller on the shared SDA/SCL lines.

---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_line_conditioner.sv | 80 ++++++++
 rtl/i2c_target_responder.sv | 177 +++++++++++++++++
 tb/tb_i2c_target_responder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target responder.
package i2c_pkg;

  localparam int BYTE_W = 8;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/i2c_line_conditioner.sv
// Synchronises SCL/SDA, optionally spike-filters them (I2C_SPIKE_FILTER_EN),
// and produces SCL edge and START/STOP pulses from the conditioned levels.
module i2c_line_conditioner (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_lvl;
  logic       sda_lvl;
  logic       scl_prev;
  logic       sda_prev;

  // NOTE: every flop here resets to 1 (idle bus level) so leaving reset never
  // looks like an SDA fall with SCL high, i.e. a spurious START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

`ifdef I2C_SPIKE_FILTER_EN
  logic [1:0] scl_hist;
  logic [1:0] sda_hist;
  logic       scl_flt;
  logic       sda_flt;

  // A level is accepted only after three equal synchronised samples in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_flt  <= 1'b1;
      sda_flt  <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      if (scl_hist == {2{scl_sync[1]}}) scl_flt <= scl_sync[1];
      if (sda_hist == {2{sda_sync[1]}}) sda_flt <= sda_sync[1];
    end
  end

  assign scl_lvl = scl_flt;
  assign sda_lvl = sda_flt;
`else
  assign scl_lvl = scl_sync[1];
  assign sda_lvl = sda_sync[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl_lvl;
      sda_prev <= sda_lvl;
    end
  end

  assign sda       = sda_lvl;
  assign scl_rise  =  scl_lvl & ~scl_prev;
  assign scl_fall  = ~scl_lvl &  scl_prev;
  // SCL must be high on both samples so an SCL edge is never read as START/STOP.
  assign start_det = scl_lvl & scl_prev &  sda_prev & ~sda_lvl;
  assign stop_det  = scl_lvl & scl_prev & ~sda_prev &  sda_lvl;

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target: address match, register pointer, burst write/read to an external bank.
// Optional SCL/SDA spike filter enabled by defining I2C_SPIKE_FILTER_EN.
module i2c_target_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h69,
  parameter logic [7:0] PTR_RST  = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  localparam logic [3:0] BITS_PER_BYTE = 4'(BYTE_W);

  logic       sda;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;

  state_t     state_q;
  state_t     state_d;
  logic       sda_oe_d;
  logic       busy_d;
  logic [7:0] shift_q;
  logic [3:0] bit_cnt_q;
  logic       ack_q;
  logic       byte_done;
  logic       shift_in_state;

  i2c_line_conditioner u_line (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign byte_done      = (bit_cnt_q == BITS_PER_BYTE);
  assign shift_in_state = (state_q == ST_ADDR) || (state_q == ST_PTR) || (state_q == ST_WDATA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      sda_oe  <= sda_oe_d;
      busy    <= busy_d;
    end
  end

  // SDA drive only changes on SCL fall (or STOP/START); the line is released in every
  // non-ACK slot except read data, where the bit is driven as ~bit.
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    state_d  = state_q;
    sda_oe_d = sda_oe;
    busy_d   = busy;
    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = ST_ADDR;
      sda_oe_d = 1'b0;
    end else if (scl_fall) begin
      unique case (state_q)
        ST_ADDR: begin
          if (byte_done) begin
            if (shift_q[7:1] == DEV_ADDR) begin
              state_d  = ST_ADDR_ACK;
              sda_oe_d = ~I2C_ACK;
              busy_d   = 1'b1;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (shift_q[0]) begin
            state_d  = ST_RDATA;
            sda_oe_d = ~reg_rdata[7];
          end else begin
            state_d  = ST_PTR;
            sda_oe_d = 1'b0;
          end
        end
        ST_PTR: begin
          if (byte_done) begin
            state_d  = ST_PTR_ACK;
            sda_oe_d = ~I2C_ACK;
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          state_d  = ST_WDATA;
          sda_oe_d = 1'b0;
        end
        ST_WDATA: begin
          if (byte_done) begin
            state_d  = ST_WDATA_ACK;
            sda_oe_d = ~I2C_ACK;
          end
        end
        ST_RDATA: begin
          if (byte_done) begin
            state_d  = ST_RDATA_ACK;
            sda_oe_d = 1'b0;
          end else begin
            sda_oe_d = ~shift_q[6];
          end
        end
        ST_RDATA_ACK: begin
          if (ack_q == I2C_ACK) begin
            state_d  = ST_RDATA;
            sda_oe_d = ~reg_rdata[7];
          end else begin
            state_d  = ST_IGNORE;
            sda_oe_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q   <= 8'h00;
      bit_cnt_q <= 4'd0;
      ack_q     <= I2C_NACK;
      reg_addr  <= PTR_RST;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      if (start_det || stop_det) begin
        bit_cnt_q <= 4'd0;
      end else if (scl_rise) begin
        if (shift_in_state && !byte_done) begin
          shift_q   <= {shift_q[6:0], sda};
          bit_cnt_q <= bit_cnt_q + 4'd1;
          if (state_q == ST_WDATA && bit_cnt_q == BITS_PER_BYTE - 4'd1) begin
            reg_wdata <= {shift_q[6:0], sda};
            reg_we    <= 1'b1;
          end
        end
        if (state_q == ST_RDATA && !byte_done) bit_cnt_q <= bit_cnt_q + 4'd1;
        // Advance before the ACK-slot fall so reg_rdata is already the next byte at reload.
        if (state_q == ST_RDATA_ACK) begin
          ack_q <= sda;
          if (sda == I2C_ACK) reg_addr <= reg_addr + 8'd1;
        end
      end else if (scl_fall) begin
        if (state_d != state_q) bit_cnt_q <= 4'd0;
        if (state_d == ST_RDATA && state_q != ST_RDATA) shift_q <= reg_rdata;
        if (state_q == ST_RDATA && state_d == ST_RDATA) shift_q <= {shift_q[6:0], 1'b0};
        if (state_q == ST_PTR && state_d == ST_PTR_ACK) reg_addr <= shift_q;
        if (state_q == ST_WDATA_ACK) reg_addr <= reg_addr + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Randomised bus-level bench with scoreboard for i2c_target_responder.
`timescale 1ns/1ps
module tb_i2c_target_responder;
  import i2c_pkg::*;

  localparam logic [6:0] DEV  = 7'h69;
  localparam logic [7:0] PTR0 = 8'h00;
  localparam int         Q    = 5;

  typedef struct packed { logic kind; logic [7:0] val; } ev_t;
  typedef struct { string name; logic [31:0] act; logic [31:0] exp; } chk_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       ctrl_sda = 1'b1;
  wire        sda_line;
  logic       sda_oe;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, busy;

  logic [7:0] bank [256];
  logic [7:0] bank_seed [256];
  logic [7:0] mdl_bank [256];
  logic       bank_load = 1'b0;
  logic [7:0] mdl_ptr;
  logic [7:0] wbuf [4];
  logic       glitch_next = 1'b0;
  int         oe_cnt = 0;
  int         checks = 0;
  int         failures = 0;

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  logic [15:0] exp_wr_q[$];
  chk_t       chk_q[$];

  assign sda_line  = ctrl_sda & ~sda_oe;
  assign reg_rdata = bank[reg_addr];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bank_load) bank <= bank_seed;
    else if (reg_we) bank[reg_addr] <= reg_wdata;
  end

  always @(posedge clk) if (sda_oe) oe_cnt <= oe_cnt + 1;

  i2c_target_responder #(.DEV_ADDR(DEV), .PTR_RST(PTR0)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sole consumer of expectations: bus events, write strobes and level checks.
  initial begin
    ev_t o, e;
    chk_t c;
    forever begin
      @(negedge clk);
      if (reg_we) begin
        if (exp_wr_q.size() == 0) check("unexpected_write", {16'h0, reg_addr, reg_wdata}, 32'hFFFF_FFFF);
        else check("write_addr_data", {16'h0, reg_addr, reg_wdata}, {16'h0, exp_wr_q.pop_front()});
      end
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        if (exp_q.size() == 0) begin
          check("unexpected_bus_event", {23'h0, o}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check(e.kind ? "read_byte" : "ack_bit", {23'h0, o}, {23'h0, e});
        end
      end
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        check(c.name, c.act, c.exp);
      end
    end
  end

  task automatic push_chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_q.push_back('{name, act, exp});
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer_bit(input logic b, output logic s);
    wait_clks(Q);
    ctrl_sda = b;
    wait_clks(Q);
    scl = 1'b1;
    if (glitch_next && b) begin
      wait_clks(2);
      ctrl_sda = 1'b0;
      wait_clks(1);
      ctrl_sda = b;
      wait_clks(Q - 3);
      glitch_next = 1'b0;
    end else begin
      wait_clks(Q);
    end
    s = sda_line;
    wait_clks(Q);
    scl = 1'b0;
  endtask

  task automatic do_start();
    if (!scl) begin
      wait_clks(Q);
      ctrl_sda = 1'b1;
      wait_clks(Q);
      scl = 1'b1;
    end
    wait_clks(Q);
    ctrl_sda = 1'b0;
    wait_clks(Q);
    scl = 1'b0;
  endtask

  task automatic do_stop();
    wait_clks(Q);
    ctrl_sda = 1'b0;
    wait_clks(Q);
    scl = 1'b1;
    wait_clks(Q);
    ctrl_sda = 1'b1;
    wait_clks(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic exp_ack);
    logic s;
    exp_q.push_back({1'b0, 7'h0, exp_ack});
    for (int i = 7; i >= 0; i--) xfer_bit(d[i], s);
    xfer_bit(1'b1, s);
    obs_q.push_back({1'b0, 7'h0, s});
  endtask

  task automatic recv_byte(input logic ack_in, input logic [7:0] exp_d);
    logic s;
    logic [7:0] d;
    exp_q.push_back({1'b1, exp_d});
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      xfer_bit(1'b1, s);
      d = {d[6:0], s};
    end
    xfer_bit(ack_in, s);
    obs_q.push_back({1'b1, d});
  endtask

  task automatic txn_write(input logic [7:0] ptr, input int n);
    do_start();
    send_byte({DEV, 1'b0}, I2C_ACK);
    push_chk("busy_addressed", 32'(busy), 32'd1);
    send_byte(ptr, I2C_ACK);
    mdl_ptr = ptr;
    for (int i = 0; i < n; i++) begin
      exp_wr_q.push_back({mdl_ptr, wbuf[i]});
      mdl_bank[mdl_ptr] = wbuf[i];
      mdl_ptr = mdl_ptr + 8'd1;
      send_byte(wbuf[i], I2C_ACK);
    end
    do_stop();
    push_chk("busy_after_stop", 32'(busy), 32'd0);
  endtask

  task automatic txn_read(input logic [7:0] ptr, input int n);
    logic ack_in;
    do_start();
    send_byte({DEV, 1'b0}, I2C_ACK);
    send_byte(ptr, I2C_ACK);
    mdl_ptr = ptr;
    do_start();
    send_byte({DEV, 1'b1}, I2C_ACK);
    push_chk("busy_read", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      ack_in = (i == n - 1) ? I2C_NACK : I2C_ACK;
      recv_byte(ack_in, mdl_bank[mdl_ptr]);
      if (ack_in == I2C_ACK) mdl_ptr = mdl_ptr + 8'd1;
    end
    do_stop();
    push_chk("busy_after_read", 32'(busy), 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (obs_q.size() + chk_q.size()) != 0; i++) @(negedge clk);
    if ((obs_q.size() + chk_q.size()) != 0) begin
      $display("FAIL drain_timeout: pending %0d required 0", obs_q.size() + chk_q.size());
      $fatal(1, "scoreboard did not drain");
    end
  endtask

  initial begin
    #700_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] p;
    logic s;
    int oe_snap;
    int n;

    for (int i = 0; i < 256; i++) begin
      bank_seed[i] = 8'($urandom);
      mdl_bank[i]  = bank_seed[i];
    end
    @(negedge clk);
    bank_load = 1'b1;
    wait_clks(2);
    bank_load = 1'b0;
    push_chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    push_chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    wait_clks(3);
    push_chk("reset_reg_addr", 32'(reg_addr), 32'(PTR0));
    push_chk("reset_reg_wdata", 32'(reg_wdata), 32'd0);
    push_chk("reset_reg_we", 32'(reg_we), 32'd0);
    push_chk("reset_sda_oe", 32'(sda_oe), 32'd0);

    // Single write, then pointer-write + repeated-START burst read.
    wbuf[0] = 8'h5C;
    txn_write(8'h4A, 1);
    txn_read(8'h10, 2);

    // Foreign address: every ACK slot reads back high and SDA is never driven.
    oe_snap = oe_cnt;
    do_start();
    send_byte(8'hA0, I2C_NACK);
    send_byte(8'h55, I2C_NACK);
    do_stop();
    push_chk("foreign_oe_count", 32'(oe_cnt - oe_snap), 32'd0);
    push_chk("foreign_busy", 32'(busy), 32'd0);

    // Pointer wrap on burst write, read back across the wrap.
    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    txn_write(8'hFF, 2);
    txn_read(8'hFF, 2);

    // Reset in the middle of a read byte whose bits are all zero.
    p = 8'($urandom);
    wbuf[0] = 8'h00;
    txn_write(p, 1);
    do_start();
    send_byte({DEV, 1'b0}, I2C_ACK);
    send_byte(p, I2C_ACK);
    do_start();
    send_byte({DEV, 1'b1}, I2C_ACK);
    for (int i = 0; i < 3; i++) begin
      xfer_bit(1'b1, s);
      push_chk("partial_read_bit", 32'(s), 32'd0);
    end
    wait_clks(Q);
    push_chk("oe_before_rst", 32'(sda_oe), 32'd1);
    push_chk("busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    push_chk("oe_in_rst", 32'(sda_oe), 32'd0);
    push_chk("busy_in_rst", 32'(busy), 32'd0);
    @(negedge clk);
    scl = 1'b1;
    wait_clks(4);
    rst = 1'b0;
    wait_clks(4);
    push_chk("post_rst_reg_addr", 32'(reg_addr), 32'(PTR0));
    txn_read(p, 1);

    for (int t = 0; t < 8; t++) begin
      p = 8'($urandom);
      n = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
      if ($urandom_range(0, 1) == 0) txn_write(p, n);
      else txn_read(p, n + 1);
    end

`ifdef I2C_SPIKE_FILTER_EN
    // One-clk SDA low with SCL high during the address MSB must not abort the byte.
    wbuf[0] = 8'($urandom);
    glitch_next = 1'b1;
    txn_write(8'($urandom), 1);
`endif

    drain();
    push_chk("exp_events_left", 32'(exp_q.size()), 32'd0);
    push_chk("exp_writes_left", 32'(exp_wr_q.size()), 32'd0);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
